// File: rtl/ex_mem_if.sv
// ex_mem_if: ID/EX-side inputs, forwarding sources and EX/MEM outputs of the execute stage.
interface ex_mem_if #(
  parameter int XLEN = 64,
  parameter int RW   = 5
);
  logic            AluSrc_in;
  logic            MemtoReg_in;
  logic            RegWrite_in;
  logic            MemRead_in;
  logic            MemWrite_in;
  logic [3:0]      alu_ctrl_in;
  logic [XLEN-1:0] rs1Data_in;
  logic [XLEN-1:0] rs2Data_in;
  logic [RW-1:0]   rs_in;
  logic [RW-1:0]   rt_in;
  logic [RW-1:0]   rd_in;
  logic [XLEN-1:0] immediate_in;
  logic            wb_RegWrite;
  logic [RW-1:0]   wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            hold_in;
  logic            flush_in;
  logic            stall_out;
  logic            zero_out;
  logic [XLEN-1:0] alu_result_out;
  logic [XLEN-1:0] store_data_out;
  logic [RW-1:0]   rd_out;
  logic            MemtoReg_out;
  logic            RegWrite_out;
  logic            MemRead_out;
  logic            MemWrite_out;

  modport master (
    output AluSrc_in, MemtoReg_in, RegWrite_in, MemRead_in, MemWrite_in, alu_ctrl_in,
    output rs1Data_in, rs2Data_in, rs_in, rt_in, rd_in, immediate_in,
    output wb_RegWrite, wb_rd, wb_data, hold_in, flush_in,
    input  stall_out, zero_out, alu_result_out, store_data_out, rd_out,
    input  MemtoReg_out, RegWrite_out, MemRead_out, MemWrite_out
  );

  modport slave (
    input  AluSrc_in, MemtoReg_in, RegWrite_in, MemRead_in, MemWrite_in, alu_ctrl_in,
    input  rs1Data_in, rs2Data_in, rs_in, rt_in, rd_in, immediate_in,
    input  wb_RegWrite, wb_rd, wb_data, hold_in, flush_in,
    output stall_out, zero_out, alu_result_out, store_data_out, rd_out,
    output MemtoReg_out, RegWrite_out, MemRead_out, MemWrite_out
  );
endinterface

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: execute stage with operand forwarding and the EX/MEM pipeline register.
// Define EX_MUL_EN to add the iterative 64-cycle shift-add multiplier (ALU code 1101).
module ex_mem_stage #(
  parameter int XLEN = 64,
  parameter int RW   = 5
) (
  input logic     clk,
  input logic     rst,
  ex_mem_if.slave bus
);
  logic [XLEN-1:0] alu_q, store_q;
  logic [RW-1:0]   rd_q;
  logic            zero_q, mtr_q, rw_q, mr_q, mw_q;
  logic [XLEN-1:0] op_a, fwd_b, op_b, alu_res, ex_res;
  logic            stall;

  // EX/MEM forwarding takes priority over MEM/WB; register 0 is never forwarded
  always_comb begin
    op_a = bus.rs1Data_in;
    if (rw_q && rd_q != '0 && rd_q == bus.rs_in)
      op_a = alu_q;
    else if (bus.wb_RegWrite && bus.wb_rd != '0 && bus.wb_rd == bus.rs_in)
      op_a = bus.wb_data;
    fwd_b = bus.rs2Data_in;
    if (rw_q && rd_q != '0 && rd_q == bus.rt_in)
      fwd_b = alu_q;
    else if (bus.wb_RegWrite && bus.wb_rd != '0 && bus.wb_rd == bus.rt_in)
      fwd_b = bus.wb_data;
  end

  assign op_b = bus.AluSrc_in ? bus.immediate_in : fwd_b;

  always_comb begin
    alu_res = '0;
    case (bus.alu_ctrl_in)
      4'b0000: alu_res = op_a & op_b;
      4'b0001: alu_res = op_a | op_b;
      4'b0010: alu_res = op_a + op_b;
      4'b0011: alu_res = op_a ^ op_b;
      4'b0110: alu_res = op_a - op_b;
      4'b0111: alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      4'b1100: alu_res = ~(op_a | op_b);
      4'b1000: alu_res = op_a << op_b[5:0];
      4'b1001: alu_res = op_a >> op_b[5:0];
      4'b1010: alu_res = $signed(op_a) >>> op_b[5:0];
      default: alu_res = '0;
    endcase
  end

`ifdef EX_MUL_EN
  typedef enum logic [1:0] {IDLE, BUSY, DONE} mul_state_t;

  mul_state_t      state;
  logic [XLEN-1:0] mcand, mplier, acc;
  logic [5:0]      cnt;
  logic            mul_start;

  assign mul_start = (state == IDLE) && (bus.alu_ctrl_in == 4'b1101) && !bus.flush_in;
  assign stall     = mul_start || (state == BUSY);
  assign ex_res    = (state == DONE) ? acc : alu_res;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: if (mul_start) begin
          mcand  <= op_a;
          mplier <= op_b;
          acc    <= '0;
          cnt    <= '0;
          state  <= BUSY;
        end
        BUSY: if (bus.flush_in) begin
          state <= IDLE;
        end else begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 6'd1;
          if (cnt == 6'd63) state <= DONE;
        end
        DONE: if (bus.flush_in || !bus.hold_in) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
`else
  assign stall  = 1'b0;
  assign ex_res = alu_res;
`endif

  // reset, flush and stall all load the same all-zero bubble, so they share one branch
  always_ff @(posedge clk) begin
    if (rst || bus.flush_in || stall) begin
      alu_q   <= '0;
      store_q <= '0;
      rd_q    <= '0;
      zero_q  <= 1'b0;
      mtr_q   <= 1'b0;
      rw_q    <= 1'b0;
      mr_q    <= 1'b0;
      mw_q    <= 1'b0;
    end else if (!bus.hold_in) begin
      alu_q   <= ex_res;
      store_q <= fwd_b;
      rd_q    <= bus.rd_in;
      zero_q  <= (ex_res == '0);
      mtr_q   <= bus.MemtoReg_in;
      rw_q    <= bus.RegWrite_in;
      mr_q    <= bus.MemRead_in;
      mw_q    <= bus.MemWrite_in;
    end
  end

  assign bus.stall_out      = stall;
  assign bus.alu_result_out = alu_q;
  assign bus.store_data_out = store_q;
  assign bus.rd_out         = rd_q;
  assign bus.zero_out       = zero_q;
  assign bus.MemtoReg_out   = mtr_q;
  assign bus.RegWrite_out   = rw_q;
  assign bus.MemRead_out    = mr_q;
  assign bus.MemWrite_out   = mw_q;
endmodule
